// File: rtl/ahb_arb_pkg.sv
// Shared constants and types for the two-requester AHB-Lite master arbiter.
// TIMEOUT_LIMIT is only consumed when AHB_ARB_TIMEOUT_EN is defined.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;
  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } arb_state_e;

  // Byte, halfword and word are the only sizes a 32-bit bus can carry.
  function automatic logic size_legal(input logic [2:0] size);
    return (size <= HSIZE_WORD);
  endfunction

endpackage

// File: rtl/ahb_master_arbiter_rr.sv
// Two-way round-robin grant with the last-grant memory; requester 1 is
// treated as the last winner after reset so requester 0 goes first.
module rr_arbiter2
  import ahb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt_idx,
  output logic       gnt_any
);

  logic last_r;

  // Pick the sole requester, or the one not served last on a tie.
  always_comb begin
    gnt_any = |req;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_r;
      default: gnt_idx = 1'b0;
    endcase
  end

  // Remember the winner whenever the grant is actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (update) begin
      last_r <= gnt_idx;
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB-Lite master port between two single-beat requesters.
// Optional transfer watchdog: define AHB_ARB_TIMEOUT_EN.
module ahb_master_arbiter
  import ahb_arb_pkg::*;
(
  input  logic        FIC_0_CLK,
  input  logic        FAB_RESET,
  input  logic        REQ0_VALID,
  input  logic [31:0] REQ0_ADDR,
  input  logic        REQ0_WRITE,
  input  logic [2:0]  REQ0_SIZE,
  input  logic [31:0] REQ0_WDATA,
  output logic        REQ0_ACCEPT,
  output logic        REQ0_DONE,
  output logic [31:0] REQ0_RDATA,
  output logic        REQ0_ERR,
  input  logic        REQ1_VALID,
  input  logic [31:0] REQ1_ADDR,
  input  logic        REQ1_WRITE,
  input  logic [2:0]  REQ1_SIZE,
  input  logic [31:0] REQ1_WDATA,
  output logic        REQ1_ACCEPT,
  output logic        REQ1_DONE,
  output logic [31:0] REQ1_RDATA,
  output logic        REQ1_ERR,
  output logic [31:0] HADDR_M0,
  output logic [1:0]  HTRANS_M0,
  output logic        HWRITE_M0,
  output logic [2:0]  HSIZE_M0,
  output logic [2:0]  HBURST_M0,
  output logic [3:0]  HPROT_M0,
  output logic        HMASTLOCK_M0,
  output logic [31:0] HWDATA_M0,
  input  logic [31:0] HRDATA_M0,
  input  logic        HREADY_M0,
  input  logic [1:0]  HRESP_M0
);

  arb_state_e  state_r, state_s;
  logic        gnt_idx_s, gnt_any_s;
  logic        take_s, complete_s, timeout_s, tmo_hit_s;
  logic        sel_legal_s, sel_write_s;
  logic [2:0]  sel_size_s;
  logic [31:0] sel_addr_s, sel_wdata_s;
  logic        cur_r, bad_pend_r, write_r;
  logic [31:0] addr_r, wdata_r, rdata0_r, rdata1_r;
  logic [2:0]  size_r;
  logic [1:0]  htrans_r, accept_r, done_r, err_r;
  logic        unused_s;

  assign unused_s = HRESP_M0[1];

  rr_arbiter2 u_rr (
    .clk     (FIC_0_CLK),
    .rst     (FAB_RESET),
    .req     ({REQ1_VALID, REQ0_VALID}),
    .update  (take_s),
    .gnt_idx (gnt_idx_s),
    .gnt_any (gnt_any_s)
  );

  assign sel_addr_s  = gnt_idx_s ? REQ1_ADDR  : REQ0_ADDR;
  assign sel_write_s = gnt_idx_s ? REQ1_WRITE : REQ0_WRITE;
  assign sel_size_s  = gnt_idx_s ? REQ1_SIZE  : REQ0_SIZE;
  assign sel_wdata_s = gnt_idx_s ? REQ1_WDATA : REQ0_WDATA;
  assign sel_legal_s = size_legal(sel_size_s);

`ifdef AHB_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt_r;

  assign tmo_hit_s = (state_r != ST_IDLE) && !HREADY_M0 &&
                     (wait_cnt_r == (TIMEOUT_LIMIT - 8'd1));

  // Count stalled bus cycles of the transfer in flight.
  always_ff @(posedge FIC_0_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      wait_cnt_r <= 8'd0;
    end else if ((state_r == ST_IDLE) || timeout_s || complete_s) begin
      wait_cnt_r <= 8'd0;
    end else if (!HREADY_M0) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state: a new grant is taken from IDLE or straight out of a finishing DATA phase.
  always_comb begin
    state_s    = state_r;
    take_s     = 1'b0;
    complete_s = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // An illegal-size request is still reporting; hold off until its DONE.
        if (gnt_any_s && !bad_pend_r) begin
          take_s  = 1'b1;
          state_s = sel_legal_s ? ST_ADDR : ST_IDLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (HREADY_M0) begin
          state_s = ST_DATA;
        end else if (tmo_hit_s) begin
          timeout_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (HREADY_M0) begin
          complete_s = 1'b1;
          if (gnt_any_s) begin
            take_s  = 1'b1;
            state_s = sel_legal_s ? ST_ADDR : ST_IDLE;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (tmo_hit_s) begin
          timeout_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_DATA;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, captured request, bus drive and per-requester completion registers.
  always_ff @(posedge FIC_0_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      state_r    <= ST_IDLE;
      cur_r      <= 1'b0;
      bad_pend_r <= 1'b0;
      addr_r     <= 32'd0;
      write_r    <= 1'b0;
      size_r     <= 3'd0;
      wdata_r    <= 32'd0;
      htrans_r   <= HTRANS_IDLE;
      accept_r   <= 2'b00;
      done_r     <= 2'b00;
      err_r      <= 2'b00;
      rdata0_r   <= 32'd0;
      rdata1_r   <= 32'd0;
    end else begin
      state_r    <= state_s;
      htrans_r   <= (state_s == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
      bad_pend_r <= take_s && !sel_legal_s;
      accept_r   <= 2'b00;
      done_r     <= 2'b00;
      err_r      <= 2'b00;
      if (take_s) begin
        cur_r              <= gnt_idx_s;
        accept_r[gnt_idx_s] <= 1'b1;
        if (sel_legal_s) begin
          addr_r  <= sel_addr_s;
          write_r <= sel_write_s;
          size_r  <= sel_size_s;
          wdata_r <= sel_wdata_s;
        end
      end
      if (bad_pend_r || timeout_s) begin
        done_r[cur_r] <= 1'b1;
        err_r[cur_r]  <= 1'b1;
      end
      if (complete_s) begin
        done_r[cur_r] <= 1'b1;
        err_r[cur_r]  <= HRESP_M0[0];
        if (!write_r) begin
          if (cur_r) begin
            rdata1_r <= HRDATA_M0;
          end else begin
            rdata0_r <= HRDATA_M0;
          end
        end
      end
    end
  end

  assign HADDR_M0     = addr_r;
  assign HTRANS_M0    = htrans_r;
  assign HWRITE_M0    = write_r;
  assign HSIZE_M0     = size_r;
  assign HBURST_M0    = HBURST_SINGLE;
  assign HPROT_M0     = HPROT_DATA;
  assign HMASTLOCK_M0 = 1'b0;
  assign HWDATA_M0    = wdata_r;
  assign REQ0_ACCEPT  = accept_r[0];
  assign REQ1_ACCEPT  = accept_r[1];
  assign REQ0_DONE    = done_r[0];
  assign REQ1_DONE    = done_r[1];
  assign REQ0_ERR     = err_r[0];
  assign REQ1_ERR     = err_r[1];
  assign REQ0_RDATA   = rdata0_r;
  assign REQ1_RDATA   = rdata1_r;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: arbitration order, latency, wait states,
// error response, illegal size, mid-transfer reset and the AHB_ARB_TIMEOUT_EN watchdog.
module tb_ahb_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, w0, v1, w1;
  logic [31:0] a0, d0, a1, d1;
  logic [2:0]  s0, s1;
  logic        acc0, done0, err0, acc1, done1, err1;
  logic [31:0] rd0, rd1;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans, hresp;
  logic        hwrite, hmastlock, hready;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int dc, ec;

  always #5 clk = ~clk;

  ahb_master_arbiter dut (
    .FIC_0_CLK(clk), .FAB_RESET(rst),
    .REQ0_VALID(v0), .REQ0_ADDR(a0), .REQ0_WRITE(w0), .REQ0_SIZE(s0), .REQ0_WDATA(d0),
    .REQ0_ACCEPT(acc0), .REQ0_DONE(done0), .REQ0_RDATA(rd0), .REQ0_ERR(err0),
    .REQ1_VALID(v1), .REQ1_ADDR(a1), .REQ1_WRITE(w1), .REQ1_SIZE(s1), .REQ1_WDATA(d1),
    .REQ1_ACCEPT(acc1), .REQ1_DONE(done1), .REQ1_RDATA(rd1), .REQ1_ERR(err1),
    .HADDR_M0(haddr), .HTRANS_M0(htrans), .HWRITE_M0(hwrite), .HSIZE_M0(hsize),
    .HBURST_M0(hburst), .HPROT_M0(hprot), .HMASTLOCK_M0(hmastlock), .HWDATA_M0(hwdata),
    .HRDATA_M0(hrdata), .HREADY_M0(hready), .HRESP_M0(hresp)
  );

  // Tally completion pulses and error completions mid-cycle.
  always @(negedge clk) begin
    if (done0 || done1) done_cnt <= done_cnt + 1;
    if ((done0 && err0) || (done1 && err1)) err_cnt <= err_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    v0 = 1'b0; w0 = 1'b0; a0 = 32'd0; d0 = 32'd0; s0 = 3'd2;
    v1 = 1'b0; w1 = 1'b0; a1 = 32'd0; d1 = 32'd0; s1 = 3'd2;
    hrdata = 32'd0; hready = 1'b1; hresp = 2'b00;
    repeat (3) cyc();

    // Reset state and constant control
    check_val("rst_htrans", {30'd0, htrans}, 32'd0);
    check_val("rst_haddr", haddr, 32'd0);
    check_val("rst_hwdata", hwdata, 32'd0);
    check_val("rst_hsize_hwrite", {28'd0, hsize, hwrite}, 32'd0);
    check_val("rst_handshake", {26'd0, acc0, acc1, done0, done1, err0, err1}, 32'd0);
    check_val("rst_rdata0", rd0, 32'd0);
    check_val("rst_rdata1", rd1, 32'd0);
    check_val("const_ctrl", {24'd0, hburst, hprot, hmastlock}, {24'd0, 3'b000, 4'b0011, 1'b0});
    rst = 1'b0;
    cyc();

    // Simultaneous writes after reset: req0 first, req1 back-to-back
    v0 = 1'b1; a0 = 32'h0000_0100; w0 = 1'b1; s0 = 3'd2; d0 = 32'h0000_0011;
    v1 = 1'b1; a1 = 32'h0000_0200; w1 = 1'b1; s1 = 3'd2; d1 = 32'h0000_0022;
    cyc();
    check_val("tie_accept", {30'd0, acc1, acc0}, 32'd1);
    check_val("tie_addr0", haddr, 32'h0000_0100);
    check_val("tie_nonseq0", {30'd0, htrans}, 32'd2);
    v0 = 1'b0;
    cyc();
    check_val("tie_hwdata0", hwdata, 32'h0000_0011);
    check_val("tie_data_idle", {30'd0, htrans}, 32'd0);
    cyc();
    check_val("tie_done0_acc1", {30'd0, done0, acc1}, 32'd3);
    check_val("tie_addr1", haddr, 32'h0000_0200);
    check_val("tie_nonseq1", {30'd0, htrans}, 32'd2);
    v1 = 1'b0;
    cyc();
    check_val("tie_hwdata1", hwdata, 32'h0000_0022);
    cyc();
    check_val("tie_done1", {30'd0, done1, err1}, 32'd2);
    check_val("tie_wr_rdata", rd0 | rd1, 32'd0);

    // Zero-wait read on req0: DONE three cycles after VALID
    v0 = 1'b1; a0 = 32'h4000_0000; w0 = 1'b0; s0 = 3'd2;
    hrdata = 32'hDEAD_BEEF;
    cyc();
    check_val("rd_accept", {31'd0, acc0}, 32'd1);
    check_val("rd_addr", haddr, 32'h4000_0000);
    check_val("rd_ctrl", {26'd0, htrans, hsize, hwrite}, {26'd0, 2'b10, 3'd2, 1'b0});
    v0 = 1'b0;
    cyc();
    check_val("rd_c2", {29'd0, htrans, done0}, 32'd0);
    cyc();
    check_val("rd_done", {30'd0, done0, err0}, 32'd2);
    check_val("rd_rdata", rd0, 32'hDEAD_BEEF);
    cyc();
    check_val("rd_done_pulse", {31'd0, done0}, 32'd0);

    // Write with four wait states in the data phase
    v0 = 1'b1; a0 = 32'h0000_0300; w0 = 1'b1; d0 = 32'hA5A5_5A5A;
    hrdata = 32'h1111_1111;
    cyc();
    v0 = 1'b0;
    d0 = 32'h0BAD_F00D;
    cyc();
    hready = 1'b0;
    check_val("ws_hwdata", hwdata, 32'hA5A5_5A5A);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_val("ws_hold", {hwdata[31:1], done0}, {31'h52D2_AD2D, 1'b0});
    end
    hready = 1'b1;
    cyc();
    check_val("ws_done", {30'd0, done0, err0}, 32'd2);
    check_val("ws_rdata_kept", rd0, 32'hDEAD_BEEF);

    // Two-cycle ERROR response on a req1 read, then a clean req0 read
    v1 = 1'b1; a1 = 32'h0000_0400; w1 = 1'b0; s1 = 3'd2;
    cyc();
    check_val("er_accept", {30'd0, acc1, acc0}, 32'd2);
    v1 = 1'b0;
    cyc();
    hready = 1'b0; hresp = 2'b01;
    cyc();
    check_val("er_wait", {31'd0, done1}, 32'd0);
    hready = 1'b1;
    cyc();
    check_val("er_done", {30'd0, done1, err1}, 32'd3);
    hresp = 2'b00;
    v0 = 1'b1; a0 = 32'h0000_0500; w0 = 1'b0; s0 = 3'd2;
    hrdata = 32'h1234_5678;
    cyc();
    v0 = 1'b0;
    cyc();
    cyc();
    check_val("er_next", {30'd0, done0, err0}, 32'd2);
    check_val("er_next_rdata", rd0, 32'h1234_5678);

    // Illegal size: no bus transfer, DONE with ERR the cycle after ACCEPT
    v1 = 1'b1; a1 = 32'h0000_0600; s1 = 3'd3;
    cyc();
    check_val("sz_accept", {30'd0, acc1, done1}, 32'd2);
    check_val("sz_no_xfer", {30'd0, htrans}, 32'd0);
    v1 = 1'b0; s1 = 3'd2;
    cyc();
    check_val("sz_done", {29'd0, htrans, done1, err1}, 32'd3);
    cyc();
    check_val("sz_pulse", {31'd0, done1}, 32'd0);

    // Reset during DATA abandons the transfer
    dc = done_cnt;
    v0 = 1'b1; a0 = 32'h0000_0700; w0 = 1'b0;
    cyc();
    v0 = 1'b0;
    cyc();
    hready = 1'b0;
    rst = 1'b1;
    #1;
    check_val("mr_bus", {haddr[31:2], htrans}, 32'd0);
    check_val("mr_flags", {26'd0, acc0, acc1, done0, done1, err0, err1}, 32'd0);
    check_val("mr_rdata", rd0, 32'd0);
    cyc();
    hready = 1'b1;
    cyc();
    rst = 1'b0;
    v1 = 1'b1; a1 = 32'h0000_0800; w1 = 1'b0; s1 = 3'd2;
    hrdata = 32'hCAFE_0001;
    cyc();
    check_val("mr_grant1", {30'd0, acc1, acc0}, 32'd2);
    check_val("mr_addr1", haddr, 32'h0000_0800);
    v1 = 1'b0;
    cyc();
    cyc();
    check_val("mr_done1", {30'd0, done1, err1}, 32'd2);
    cyc();
    check_val("mr_done_count", done_cnt - dc, 32'd1);

    // Bus stall of 300 cycles: watchdog build completes with ERR, default build waits
    dc = done_cnt; ec = err_cnt;
    v0 = 1'b1; a0 = 32'h0000_0900; w0 = 1'b0;
    cyc();
    v0 = 1'b0;
    cyc();
    hready = 1'b0;
    repeat (300) cyc();
`ifdef AHB_ARB_TIMEOUT_EN
    check_val("to_done", done_cnt - dc, 32'd1);
    check_val("to_err", err_cnt - ec, 32'd1);
    check_val("to_idle", {30'd0, htrans}, 32'd0);
`else
    check_val("to_no_done", done_cnt - dc, 32'd0);
    check_val("to_no_err", err_cnt - ec, 32'd0);
`endif
    hready = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    check_val("end_idle", {30'd0, htrans}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have ports: FIC_0_CLK  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have ports: FAB_RESET  in  1  async active-high reset.
REQ-004 SHALL have per requester n in {0,1}: REQn_VALID in 1; REQn_ADDR in 32; REQn_WRITE in 1; REQn_SIZE in 3 (HSIZE encoding, 0..2 legal); REQn_WDATA in 32 -- single-beat transfer request.
REQ-005 SHALL have per requester: REQn_ACCEPT out 1 (request taken this cycle); REQn_DONE out 1 (one-cycle completion pulse); REQn_RDATA out 32; REQn_ERR out 1 (valid with DONE).
REQ-006 SHALL have AHB-Lite master outputs HADDR_M0 32, HTRANS_M0 2, HWRITE_M0 1, HSIZE_M0 3, HBURST_M0 3, HPROT_M0 4, HMASTLOCK_M0 1, HWDATA_M0 32.
REQ-007 SHALL have AHB-Lite inputs HRDATA_M0 32, HREADY_M0 1, HRESP_M0 2 (bit 0 = ERROR).

Function
REQ-008 SHALL share one AHB-Lite master port between two requesters, single transfers only.
REQ-009 SHALL drive HBURST_M0=3'b000 (SINGLE), HPROT_M0=4'b0011, HMASTLOCK_M0=0 constantly.
REQ-010 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE (or ADDR on back-to-back).
REQ-011 IDLE: when any REQn_VALID, SHALL grant round-robin (priority to requester not granted last; after reset requester 0 first), assert REQn_ACCEPT for one cycle, register addr/write/size/wdata, go to ADDR.
REQ-012 ADDR: SHALL drive HTRANS_M0=NONSEQ(2'b10) with registered address/control; advance to DATA on HREADY_M0=1, else hold all outputs.
REQ-013 DATA: SHALL drive HTRANS_M0=IDLE(2'b00), HWDATA_M0=registered wdata; on HREADY_M0=1 pulse REQn_DONE, load REQn_RDATA from HRDATA_M0 (reads; writes leave it unchanged), REQn_ERR=HRESP_M0[0].
REQ-014 SHALL tolerate HRESP ERROR two-cycle response: completion taken on the cycle HREADY_M0=1.
REQ-015 Outside ADDR, HTRANS_M0 SHALL be IDLE; latency VALID->DONE = 3 cycles with zero wait states.
REQ-016 Simultaneous VALID on both SHALL grant per REQ-011; loser stays pending and is granted next IDLE slot.
REQ-017 Requesters SHALL hold REQn fields stable until ACCEPT; arbiter ignores changes after ACCEPT.
REQ-018 REQn_SIZE > 2 SHALL complete in IDLE path with ERR=1, DONE one cycle after ACCEPT, no AHB transfer.

Reset
REQ-019 On FAB_RESET=1: FSM=IDLE, HTRANS_M0=IDLE, HADDR/HWDATA/HSIZE/HWRITE=0, all ACCEPT/DONE/ERR=0, RDATA=0, last-grant=requester 1.
REQ-020 Reset mid-transfer SHALL abandon it without DONE pulse; first grant after release per REQ-011.

Configuration
REQ-021 Macro AHB_ARB_TIMEOUT_EN defined: 8-bit counter counts HREADY_M0=0 cycles in ADDR/DATA; at 255 SHALL return to IDLE, pulse DONE with ERR=1, HTRANS_M0=IDLE.
REQ-022 Macro undefined: no counter; wait indefinitely for HREADY_M0.

Structure
REQ-023 Package ahb_arb_pkg SHALL hold HTRANS/HSIZE/HBURST constants, FSM state typedef, timeout limit constant.
REQ-024 Sub-module rr_arbiter2 SHALL contain the round-robin grant and last-grant register.

Verification
REQ-025 Req0 read 0x4000_0000, zero wait, HRDATA=0xDEADBEEF -> NONSEQ one cycle, DONE0 on cycle 3, RDATA0=0xDEADBEEF, ERR0=0.
REQ-026 Both VALID same cycle after reset, writes 0x11 / 0x22 -> req0 transfer first, req1 immediately after, HWDATA order 0x11, 0x22.
REQ-027 Write with HREADY low 4 cycles in DATA -> HWDATA held stable, DONE on fifth cycle.
REQ-028 HRESP=ERROR two-cycle response on req1 read -> DONE1 with ERR1=1, next transfer unaffected.
REQ-029 FAB_RESET pulsed in DATA -> no DONE, outputs per REQ-019, next VALID on req1 granted after release.
REQ-030 With AHB_ARB_TIMEOUT_EN, HREADY held low 300 cycles -> DONE with ERR=1 after 255 wait cycles; without macro, no DONE.
